// File: rtl/serial_word_tx.sv
// serial_word_tx: valid/ready word framer that serializes WIDTH bits, one per clock, onto so.
// A new word may be accepted on the last-bit cycle so consecutive words stream without a gap.
module serial_word_tx #(
    parameter int   WIDTH     = 4,
    parameter bit   LSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             so,
    output logic             so_en,
    output logic             word_done,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sh_q;
    logic             so_q, so_en_q, done_q;
    logic             last, accept;

    assign last       = (state_q == SHIFT) && (cnt_q == LAST);
    assign load_ready = ~clear & ((state_q == IDLE) | last);
    assign accept     = load_valid & load_ready;

    // sh_q holds only the bits not yet presented; so_q is the bit on the wire now
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            so_q    <= IDLE_BIT;
            so_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            so_q    <= LSB_FIRST ? data_in[0] : data_in[WIDTH-1];
            sh_q    <= LSB_FIRST ? (data_in >> 1) : (data_in << 1);
            so_en_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (last) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            so_q    <= IDLE_BIT;
            so_en_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == SHIFT) begin
            cnt_q   <= cnt_q + 1'b1;
            so_q    <= LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];
            sh_q    <= LSB_FIRST ? (sh_q >> 1) : (sh_q << 1);
            done_q  <= (cnt_q == PENULT);
        end
    end

    assign so        = so_q;
    assign so_en     = so_en_q;
    assign word_done = done_q;
    assign busy      = so_en_q;
endmodule

// File: tb/tb_serial_word_tx.sv
// tb_serial_word_tx: random and directed stimulus on a 4-bit LSB-first and an 8-bit MSB-first
// instance, checked against a queue of bits that are still due on the wire.
module tb_serial_word_tx;
    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] data_a;
    logic [7:0] data_b;
    logic       valid_a, valid_b;
    logic       ready_a, so_a, so_en_a, done_a, busy_a;
    logic       ready_b, so_b, so_en_b, done_b, busy_b;
    logic [3:0] down_a;
    logic [7:0] down_b;
    int         qa[$];
    int         qb[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .clear(clear), .data_in(data_a), .load_valid(valid_a), .load_ready(ready_a),
        .so(so_a), .so_en(so_en_a), .word_done(done_a), .busy(busy_a));

    serial_word_tx #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_b (
        .clk(clk), .clear(clear), .data_in(data_b), .load_valid(valid_b), .load_ready(ready_b),
        .so(so_b), .so_en(so_en_b), .word_done(done_b), .busy(busy_b));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Each queue entry is one future cycle on so: bit 0 = data, bit 1 = last bit of word
    task automatic step(input logic clr, input logic va, input logic [3:0] da,
                        input logic vb, input logic [7:0] db);
        bit acc_a, acc_b;
        clear = clr; valid_a = va; data_a = da; valid_b = vb; data_b = db;
        if (clr) begin
            qa.delete(); qb.delete(); down_a = '0; down_b = '0;
        end
        #1;
        check("a_so_en", int'(so_en_a), int'(qa.size() > 0));
        check("a_busy", int'(busy_a), int'(qa.size() > 0));
        check("a_so", int'(so_a), qa.size() > 0 ? (qa[0] & 1) : 0);
        check("a_done", int'(done_a), qa.size() > 0 ? (qa[0] >> 1) : 0);
        check("a_ready", int'(ready_a), int'(!clr && qa.size() <= 1));
        check("b_so_en", int'(so_en_b), int'(qb.size() > 0));
        check("b_busy", int'(busy_b), int'(qb.size() > 0));
        check("b_so", int'(so_b), qb.size() > 0 ? (qb[0] & 1) : 0);
        check("b_done", int'(done_b), qb.size() > 0 ? (qb[0] >> 1) : 0);
        check("b_ready", int'(ready_b), int'(!clr && qb.size() <= 1));
        acc_a = va && !clr && qa.size() <= 1;
        acc_b = vb && !clr && qb.size() <= 1;
        if (so_en_a) down_a = {so_a, down_a[3:1]};
        if (so_en_b) down_b = {down_b[6:0], so_b};
        @(posedge clk);
        if (!clr) begin
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc_a) for (int k = 0; k < 4; k++) qa.push_back(int'(da[k]) | (k == 3 ? 2 : 0));
            if (acc_b) for (int k = 0; k < 8; k++) qb.push_back(int'(db[7-k]) | (k == 7 ? 2 : 0));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
    endtask

    initial begin
        clear = 1'b1; valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
        down_a = '0; down_b = '0;
        step(1'b1, 1'b1, 4'hF, 1'b1, 8'hFF);
        step(1'b1, 1'b0, 4'h0, 1'b0, 8'h00);
        idle(10);
        step(1'b0, 1'b1, 4'b1011, 1'b0, 8'h00);
        idle(5);
        check("a_down_1011", int'(down_a), 'hB);
        step(1'b0, 1'b1, 4'hA, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hA, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'h5, 1'b0, 8'h00);
        idle(5);
        check("a_down_5", int'(down_a), 'h5);
        step(1'b0, 1'b1, 4'h9, 1'b0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 1'b0, 8'h00);
        step(1'b1, 1'b1, 4'h6, 1'b1, 8'h11);
        step(1'b0, 1'b1, 4'h6, 1'b0, 8'h00);
        idle(5);
        check("a_down_6", int'(down_a), 'h6);
        step(1'b0, 1'b0, 4'h0, 1'b1, 8'hC3);
        idle(9);
        check("b_down_c3", int'(down_b), 'hC3);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, 4'($urandom),
                 $urandom_range(0, 9) < 7, 8'($urandom));
        idle(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
